// File: rtl/nn_pkg.sv
// Shared types and constants for the quantised NN pipeline layers.
package nn_pkg;

   // Default datapath widths, shared with the ROM generator
   localparam int unsigned NN_DW    = 8;
   localparam int unsigned NN_ACC_W = 20;

   // Sequencer states of the time-multiplexed linear layer
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      WB   = 2'd2,
      DONE = 2'd3
   } lin_state_e;

   // Index width that stays at least one bit wide for tiny sizes
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_linear_requant.sv
// Requantiser: round half up, arithmetic shift, signed saturation.
// Build macro SEQ_LINEAR_RELU_EN fuses a ReLU (negative results become 0).
module seq_linear_requant #(
   parameter int unsigned ACC_W = 20,
   parameter int unsigned DW    = 8,
   parameter int unsigned SHIFT = 7
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [DW-1:0]    res_c
);

   // One guard bit so the rounding offset can never wrap
   localparam int unsigned EW = ACC_W + 1;
   localparam logic signed [EW-1:0] MAX_V = {{(EW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [EW-1:0] MIN_V = {{(EW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   logic signed [EW-1:0] ext_c;
   logic signed [EW-1:0] shf_c;
   logic signed [DW-1:0] sat_c;

   assign ext_c = {acc[ACC_W-1], acc};

   // Round half up then shift; a zero shift passes the accumulator through
   if (SHIFT > 0) begin : g_round
      localparam logic signed [EW-1:0] HALF = EW'(1) << (SHIFT - 1);
      assign shf_c = (ext_c + HALF) >>> SHIFT;
   end else begin : g_pass
      assign shf_c = ext_c;
   end

   // Clamp to the signed DW-bit range
   always_comb begin
      if (shf_c > MAX_V) begin
         sat_c = MAX_V[DW-1:0];
      end else if (shf_c < MIN_V) begin
         sat_c = MIN_V[DW-1:0];
      end else begin
         sat_c = shf_c[DW-1:0];
      end
   end

   // Optional fused ReLU on the saturated value
   always_comb begin
      res_c = sat_c;
`ifdef SEQ_LINEAR_RELU_EN
      if (sat_c[DW-1]) begin
         res_c = '0;
      end
`else
`endif
   end

endmodule

// File: rtl/seq_linear_mac.sv
// Time-multiplexed fully-connected layer: one signed MAC sequenced over all
// N_OUT*N_IN weight pairs, bias from an external ROM, requantised outputs.
// Build macro SEQ_LINEAR_RELU_EN enables a fused ReLU in the requantiser.
module seq_linear_mac
   import nn_pkg::*;
#(
   parameter int unsigned N_IN  = 4,
   parameter int unsigned N_OUT = 4,
   parameter int unsigned DW    = NN_DW,
   parameter int unsigned ACC_W = NN_ACC_W,
   parameter int unsigned SHIFT = 7
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   output logic                              busy,
   output logic                              done,
   input  logic [N_IN*DW-1:0]                in_vec,
   output logic [N_OUT*DW-1:0]               out_vec,
   output logic [idx_w(N_IN*N_OUT)-1:0]      w_addr,
   input  logic signed [DW-1:0]              w_data,
   output logic [idx_w(N_OUT)-1:0]           b_addr,
   input  logic signed [ACC_W-1:0]           b_data
);

   localparam int unsigned I_W  = idx_w(N_IN);
   localparam int unsigned J_W  = idx_w(N_OUT);
   localparam int unsigned WA_W = idx_w(N_IN * N_OUT);
   localparam int unsigned PW   = 2 * DW;

   // Elaboration-time parameter sanity
   if (ACC_W < 2 * DW + $clog2(N_IN) + 1) begin : g_chk_acc_w
      $error("seq_linear_mac: ACC_W too narrow for N_IN and DW");
   end
   if (SHIFT >= ACC_W) begin : g_chk_shift
      $error("seq_linear_mac: SHIFT must be below ACC_W");
   end

   lin_state_e state_q, state_d;

   logic signed [DW-1:0]    x_q [N_IN];
   logic signed [DW-1:0]    res_q [N_OUT];
   logic [I_W-1:0]          i_q;
   logic [J_W-1:0]          j_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [PW-1:0]    prod_c;
   logic signed [ACC_W-1:0] prod_ext_c;
   logic signed [DW-1:0]    q_c;
   logic                    last_i_c;
   logic                    last_j_c;

   assign last_i_c   = (i_q == I_W'(N_IN - 1));
   assign last_j_c   = (j_q == J_W'(N_OUT - 1));
   assign prod_c     = x_q[i_q] * w_data;
   assign prod_ext_c = {{(ACC_W-PW){prod_c[PW-1]}}, prod_c};
   assign b_addr     = j_q;

   seq_linear_requant #(
      .ACC_W (ACC_W),
      .DW    (DW),
      .SHIFT (SHIFT)
   ) u_requant (
      .acc   (acc_q),
      .res_c (q_c)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = MAC;
         MAC:     if (last_i_c) state_d = WB;
         WB:      state_d = last_j_c ? DONE : MAC;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered handshake outputs, derived from the upcoming state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_d == MAC) || (state_d == WB);
         done <= (state_d == DONE);
      end
   end

   // Datapath: operand latch, MAC accumulation, lane write-back, publish
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(N_IN); k++) x_q[k] <= '0;
         for (int k = 0; k < int'(N_OUT); k++) res_q[k] <= '0;
         i_q     <= '0;
         j_q     <= '0;
         acc_q   <= '0;
         w_addr  <= '0;
         out_vec <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  for (int k = 0; k < int'(N_IN); k++) x_q[k] <= in_vec[k*DW +: DW];
                  i_q    <= '0;
                  j_q    <= '0;
                  w_addr <= '0;
               end
            end
            MAC: begin
               acc_q <= (i_q == '0) ? (b_data + prod_ext_c) : (acc_q + prod_ext_c);
               i_q   <= last_i_c ? '0 : i_q + I_W'(1);
               if (!last_i_c) w_addr <= w_addr + WA_W'(1);
            end
            WB: begin
               res_q[j_q] <= q_c;
               if (!last_j_c) begin
                  j_q    <= j_q + J_W'(1);
                  w_addr <= w_addr + WA_W'(1);
               end else begin
                  // All lanes become visible together on entry to DONE
                  for (int k = 0; k < int'(N_OUT); k++) begin
                     out_vec[k*DW +: DW] <= (J_W'(k) == j_q) ? q_c : res_q[k];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_linear_mac.sv
// Scoreboard bench for seq_linear_mac with default parameters.
module tb_seq_linear_mac;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic               busy;
   logic               done;
   logic [31:0]        in_vec;
   logic [31:0]        out_vec;
   logic [3:0]         w_addr;
   logic signed [7:0]  w_data;
   logic [1:0]         b_addr;
   logic signed [19:0] b_data;

   logic signed [7:0]  w_rom [16];
   logic signed [19:0] b_rom [4];

   logic [31:0] exp_q [$];
   logic [31:0] prev_exp;
   int          n_checks;
   int          n_fail;

   assign w_data = w_rom[w_addr];
   assign b_data = b_rom[b_addr];

   seq_linear_mac dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .in_vec  (in_vec),
      .out_vec (out_vec),
      .w_addr  (w_addr),
      .w_data  (w_data),
      .b_addr  (b_addr),
      .b_data  (b_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: each done pulse consumes one expected result
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("out_vec", 64'(out_vec), 64'(e));
         end
      end
   end

   task automatic set_w_all(input logic signed [7:0] v);
      for (int k = 0; k < 16; k++) w_rom[k] = v;
   endtask

   task automatic set_b(input int b0, input int b1, input int b2, input int b3);
      b_rom[0] = 20'(b0);
      b_rom[1] = 20'(b1);
      b_rom[2] = 20'(b2);
      b_rom[3] = 20'(b3);
   endtask

   // One run: accept, per-cycle address/hold checks, latency and busy count
   task automatic run(input logic [31:0] x, input logic [31:0] exp, input bit spurious);
      int lat;
      int busy_n;
      int jj;
      int ii;
      bit seen;
      @(negedge clk);
      in_vec = x;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      in_vec = $urandom;
      exp_q.push_back(exp);
      chk("accept_busy", 64'(busy), 64'(1));
      lat    = 0;
      busy_n = 0;
      seen   = 1'b0;
      while (!seen && lat < 60) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) busy_n++;
            if (lat < 20) begin
               jj = lat / 5;
               ii = lat % 5;
               chk("w_addr", 64'(w_addr), 64'((ii < 4) ? jj * 4 + ii : jj * 4 + 3));
               chk("b_addr", 64'(b_addr), 64'(jj));
            end
            chk("out_hold", 64'(out_vec), 64'(prev_exp));
            if (spurious) start = (lat == 4) || (lat == 18);
            @(posedge clk);
            #1;
            lat++;
         end
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout actual=%0d required=20", lat);
      end
      chk("latency", 64'(lat), 64'(20));
      chk("busy_cycles", 64'(busy_n), 64'(20));
      chk("busy_at_done", 64'(busy), 64'(0));
      if (spurious) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("done_one_cycle", 64'(done), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      prev_exp = exp;
   endtask

   // Abort a run with reset ten cycles in
   task automatic reset_mid_run(input logic [31:0] x);
      @(negedge clk);
      in_vec = x;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_out_vec", 64'(out_vec), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("post_rst_busy", 64'(busy), 64'(0));
      chk("post_rst_out_vec", 64'(out_vec), 64'(0));
      prev_exp = '0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      prev_exp = '0;
      rst_n    = 1'b0;
      start    = 1'b0;
      in_vec   = '0;
      set_w_all(8'sd0);
      set_b(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      chk("reset_out_vec", 64'(out_vec), 64'(0));
      chk("reset_w_addr", 64'(w_addr), 64'(0));
      chk("reset_b_addr", 64'(b_addr), 64'(0));

      // Identity: 64*127 = 8128, (8128+64)>>7 = 64
      set_w_all(8'sd0);
      w_rom[0] = 8'sd127;
      run(32'h0000_0040, 32'h0000_0040, 1'b0);

      // Positive saturation: 4*127*127 -> 504 -> 127
      set_w_all(8'sd127);
      run(32'h7f7f_7f7f, 32'h7f7f_7f7f, 1'b0);

      // Negative saturation: -504 -> -128
      set_w_all(-8'sd127);
`ifdef SEQ_LINEAR_RELU_EN
      run(32'h7f7f_7f7f, 32'h0000_0000, 1'b0);
`else
      run(32'h7f7f_7f7f, 32'h8080_8080, 1'b0);
`endif

      // Bias and rounding with x = 0
      set_b(63, 64, -64, 384);
      run(32'h0000_0000, 32'h0300_0100, 1'b0);
      set_b(-65, 0, 0, 0);
`ifdef SEQ_LINEAR_RELU_EN
      run(32'h0000_0000, 32'h0000_0000, 1'b0);
`else
      run(32'h0000_0000, 32'h0000_00ff, 1'b0);
`endif

      // Ignored mid-run starts, then a back-to-back run
      // x=[10,20,30,40], w=64: 6400 -> 50; lane3 bias -6400 -> 0
      set_w_all(8'sd64);
      set_b(0, 0, 0, -6400);
      run(32'h281e_140a, 32'h0032_3232, 1'b1);
      // x negated: lanes0-2 -6336>>>7 = -50, lane3 -12736>>>7 = -100
`ifdef SEQ_LINEAR_RELU_EN
      run(32'hd8e2_ecf6, 32'h0000_0000, 1'b0);
`else
      run(32'hd8e2_ecf6, 32'h9cce_cece, 1'b0);
`endif

      // Reset mid-run aborts, next run completes normally
      run(32'h281e_140a, 32'h0032_3232, 1'b0);
      reset_mid_run(32'h281e_140a);
      run(32'h281e_140a, 32'h0032_3232, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
